// File: rtl/regfile_debug_port.sv
// Debug-host initiator for the 32x32 integer register file: halts the core, performs one
// read or write through the register file's debug port, and returns a response.
module regfile_debug_port #(
    parameter int HALT_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dbg_req_valid,
    output logic        dbg_req_ready,
    input  logic        dbg_req_write,
    input  logic [4:0]  dbg_req_addr,
    input  logic [31:0] dbg_req_wdata,
    output logic        dbg_rsp_valid,
    input  logic        dbg_rsp_ready,
    output logic [31:0] dbg_rsp_rdata,
    output logic        dbg_rsp_err,
    output logic        core_halt_req,
    input  logic        core_halted,
    output logic [4:0]  rf_addr,
    output logic        rf_we,
    output logic [31:0] rf_wdata,
    input  logic [31:0] rf_rdata
);

    localparam int CNT_W = $clog2(HALT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HALT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]       state;
    logic             req_write;
    logic [4:0]       req_addr;
    logic [31:0]      req_wdata;
    logic [CNT_W-1:0] halt_cnt;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic             wr_x0;

    assign wr_x0 = req_write && (req_addr == 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            halt_cnt  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dbg_req_valid) begin
                        req_write <= dbg_req_write;
                        req_addr  <= dbg_req_addr;
                        req_wdata <= dbg_req_wdata;
                        halt_cnt  <= '0;
                        state     <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    // A halt acknowledge on the same edge as the timeout still gets the access.
                    if (core_halted) begin
                        state <= ST_ACCESS;
                    end else if (halt_cnt >= CNT_LAST) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        halt_cnt <= halt_cnt + 1'b1;
                    end
                end
                ST_ACCESS: begin
                    rsp_rdata <= req_write ? 32'd0 : rf_rdata;
                    rsp_err   <= wr_x0;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (dbg_rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so an async reset clears them at once.
    assign dbg_req_ready = (state == ST_IDLE);
    assign core_halt_req = (state != ST_IDLE);
    assign rf_we         = (state == ST_ACCESS) && req_write && !wr_x0;
    assign rf_addr       = (state == ST_ACCESS) ? req_addr  : 5'd0;
    assign rf_wdata      = (state == ST_ACCESS) ? req_wdata : 32'd0;
    assign dbg_rsp_valid = (state == ST_RESP);
    assign dbg_rsp_rdata = (state == ST_RESP) ? rsp_rdata : 32'd0;
    assign dbg_rsp_err   = (state == ST_RESP) && rsp_err;

endmodule
